// File: rtl/control_pkg.sv
// Shared definitions for the instruction-sequencing control unit:
// state encoding, opcode constants, opcode classes and IR field helpers.
package control_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_ALU3,
        CLS_MD,
        CLS_HALT
    } op_class_t;

    localparam logic [4:0] OP_ROL       = 5'b01011;
    localparam logic [4:0] OP_MUL       = 5'b01111;
    localparam logic [4:0] OP_DIV       = 5'b10000;
    localparam logic [4:0] OP_HALT      = 5'b11011;
    localparam logic [4:0] OP_ALU3_LAST = 5'b01100;

    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    function automatic logic [4:0] opcode_of(input logic [31:0] ir);
        return ir[OPC_LSB +: 5];
    endfunction

    function automatic logic [3:0] ra_of(input logic [31:0] ir);
        return ir[RA_LSB +: 4];
    endfunction

    function automatic logic [3:0] rb_of(input logic [31:0] ir);
        return ir[RB_LSB +: 4];
    endfunction

    function automatic logic [3:0] rc_of(input logic [31:0] ir);
        return ir[RC_LSB +: 4];
    endfunction

    function automatic op_class_t classify(input logic [4:0] op);
        if (op <= OP_ALU3_LAST)
            return CLS_ALU3;
        else if (op == OP_MUL || op == OP_DIV)
            return CLS_MD;
        else if (op == OP_HALT)
            return CLS_HALT;
        else
            return CLS_NOP;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: run/memory handshake, instruction word
// and every datapath strobe driven by the sequencer.
interface control_unit_if;

    logic        run_req;
    logic        mem_ready;
    logic [31:0] IR_Data;

    logic        PC_select;
    logic        PC_enable;
    logic        PC_increment_enable;
    logic        IR_enable;
    logic        MAR_enable;
    logic        MDR_enable;
    logic        MDR_select;
    logic        read;
    logic        Y_enable;
    logic        Z_enable;
    logic        Z_HI_select;
    logic        Z_LO_select;
    logic        HI_enable;
    logic        LO_enable;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic [4:0]  alu_instruction;
    logic        running;

    modport master (
        input  run_req, mem_ready, IR_Data,
        output PC_select, PC_enable, PC_increment_enable, IR_enable,
        output MAR_enable, MDR_enable, MDR_select, read,
        output Y_enable, Z_enable, Z_HI_select, Z_LO_select,
        output HI_enable, LO_enable, reg_in, reg_out,
        output alu_instruction, running
    );

    modport slave (
        output run_req, mem_ready, IR_Data,
        input  PC_select, PC_enable, PC_increment_enable, IR_enable,
        input  MAR_enable, MDR_enable, MDR_select, read,
        input  Y_enable, Z_enable, Z_HI_select, Z_LO_select,
        input  HI_enable, LO_enable, reg_in, reg_out,
        input  alu_instruction, running
    );

endinterface

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select with enable; all zero when disabled.
module reg_select_decoder (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en)
            onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch (T0-T2), decode and execute
// (T3-T6), with IDLE entry gated by run_req and an absorbing HALT.
module control_unit
    import control_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    control_unit_if.master bus
);

    state_t    state;
    state_t    next;
    op_class_t cls;
    logic      rin_en;
    logic      rout_en;
    logic [3:0] rout_sel;
    logic [15:0] reg_in_w;
    logic [15:0] reg_out_w;
    logic      unused_ir;

    assign cls       = classify(opcode_of(bus.IR_Data));
    assign unused_ir = ^bus.IR_Data[14:0];

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= next;
    end

    always_comb begin
        next                    = state;
        bus.PC_select           = 1'b0;
        bus.PC_enable           = 1'b0;
        bus.PC_increment_enable = 1'b0;
        bus.IR_enable           = 1'b0;
        bus.MAR_enable          = 1'b0;
        bus.MDR_enable          = 1'b0;
        bus.MDR_select          = 1'b0;
        bus.read                = 1'b0;
        bus.Y_enable            = 1'b0;
        bus.Z_enable            = 1'b0;
        bus.Z_HI_select         = 1'b0;
        bus.Z_LO_select         = 1'b0;
        bus.HI_enable           = 1'b0;
        bus.LO_enable           = 1'b0;
        bus.alu_instruction     = 5'd0;
        rin_en                  = 1'b0;
        rout_en                 = 1'b0;
        rout_sel                = 4'd0;
        unique case (state)
            S_IDLE: begin
                if (bus.run_req)
                    next = S_T0;
            end
            S_T0: begin
                bus.PC_select           = 1'b1;
                bus.MAR_enable          = 1'b1;
                bus.PC_increment_enable = 1'b1;
                bus.Z_enable            = 1'b1;
                next                    = S_T1;
            end
            S_T1: begin
                // PC only latches on the ready cycle so a stalled fetch
                // advances it exactly once.
                bus.Z_LO_select = 1'b1;
                bus.read        = 1'b1;
                bus.MDR_enable  = 1'b1;
                bus.PC_enable   = bus.mem_ready;
                if (bus.mem_ready)
                    next = S_T2;
            end
            S_T2: begin
                bus.MDR_select = 1'b1;
                bus.IR_enable  = 1'b1;
                next           = S_T3;
            end
            S_T3: begin
                unique case (cls)
                    CLS_ALU3, CLS_MD: begin
                        rout_en      = 1'b1;
                        rout_sel     = rb_of(bus.IR_Data);
                        bus.Y_enable = 1'b1;
                        next         = S_T4;
                    end
                    CLS_HALT: next = S_HALT;
                    default:  next = bus.run_req ? S_T0 : S_IDLE;
                endcase
            end
            S_T4: begin
                rout_en             = 1'b1;
                rout_sel            = rc_of(bus.IR_Data);
                bus.Z_enable        = 1'b1;
                bus.alu_instruction = opcode_of(bus.IR_Data);
                next                = S_T5;
            end
            S_T5: begin
                bus.Z_LO_select = 1'b1;
                if (cls == CLS_MD) begin
                    bus.LO_enable = 1'b1;
                    next          = S_T6;
                end else begin
                    rin_en = 1'b1;
                    next   = bus.run_req ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                bus.Z_HI_select = 1'b1;
                bus.HI_enable   = 1'b1;
                next            = bus.run_req ? S_T0 : S_IDLE;
            end
            S_HALT: next = S_HALT;
            default: next = S_IDLE;
        endcase
    end

    assign bus.running = (state != S_IDLE) && (state != S_HALT);

    reg_select_decoder u_dec_in (
        .en     (rin_en),
        .sel    (ra_of(bus.IR_Data)),
        .onehot (reg_in_w)
    );

    reg_select_decoder u_dec_out (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (reg_out_w)
    );

    assign bus.reg_in  = reg_in_w;
    assign bus.reg_out = reg_out_w;

endmodule
